// File: rtl/min_weight_solution_sink_pkg.sv
// Shared aoc package: state types and width helpers used by the stream blocks.
package aoc_pkg;

  typedef enum logic [0:0] {
    STATE__RECEIVE = 1'b0,
    STATE__REPORT  = 1'b1
  } state_t;

  // Bits needed to hold a popcount of n bits (0..n inclusive).
  function automatic int weight_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/min_weight_solution_sink_if.sv
// AXI-stream style handshake bundle carrying solution frames.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/min_weight_solution_sink_popcount.sv
// Combinational popcount over the n MSB-aligned bits of a MAX_N-bit vector.
module popcount
  import aoc_pkg::*;
#(
  parameter int MAX_N = 8
) (
  input  logic [MAX_N-1:0]               bits,
  input  logic [weight_width(MAX_N)-1:0] n,
  output logic [weight_width(MAX_N)-1:0] count
);
  localparam int CW = weight_width(MAX_N);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      count = count + CW'(bits[MAX_N-1-i] && (i < 32'(n)));
    end
  end
endmodule

// File: rtl/min_weight_solution_sink.sv
// Tracks the minimum solution popcount per frame, reports it with a
// valid/ready handshake, and accumulates accepted minima across frames.
module min_weight_solution_sink
  import aoc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WEIGHT_W   = weight_width(DATA_WIDTH),
  parameter int SUM_W      = 16,
  parameter int BEATS_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  axi_stream_if.slave         solution_stream,
  input  logic                clear,
  output logic [WEIGHT_W-1:0] min_weight,
  output logic [BEATS_W-1:0]  frame_beats,
  output logic                min_valid,
  input  logic                min_ready,
  output logic [SUM_W-1:0]    total_sum,
  output logic [BEATS_W-1:0]  frame_count
);
  localparam int PCW = weight_width(DATA_WIDTH);

  state_t state, state_next;

  logic [PCW-1:0]      pc_count;
  logic [WEIGHT_W-1:0] weight;
  logic [WEIGHT_W-1:0] running_min, min_next;
  logic [BEATS_W-1:0]  beat_cnt, cnt_next;
  logic                first;
  logic                accept, take;
  logic [SUM_W-1:0]    sum_base, sum_next;
  logic [SUM_W:0]      sum_ext;
  logic [BEATS_W-1:0]  count_base, count_next;

  popcount #(.MAX_N(DATA_WIDTH)) u_popcount (
    .bits  (solution_stream.tdata),
    .n     (PCW'(DATA_WIDTH)),
    .count (pc_count)
  );

  assign weight = WEIGHT_W'(pc_count);
  assign accept = solution_stream.tvalid && solution_stream.tready;
  assign take   = min_valid && min_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= STATE__RECEIVE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      STATE__RECEIVE: if (accept && solution_stream.tlast) state_next = STATE__REPORT;
      STATE__REPORT:  if (min_ready) state_next = STATE__RECEIVE;
      default:        state_next = STATE__RECEIVE;
    endcase
  end

  always_comb begin
    solution_stream.tready = (state == STATE__RECEIVE);
    min_valid              = (state == STATE__REPORT);
  end

  always_comb begin
    min_next = first ? weight : ((weight < running_min) ? weight : running_min);
    if (first)               cnt_next = BEATS_W'(1);
    else if (beat_cnt == '1) cnt_next = beat_cnt;
    else                     cnt_next = beat_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_min <= '0;
      beat_cnt    <= '0;
      first       <= 1'b1;
      min_weight  <= '0;
      frame_beats <= '0;
    end else if (accept) begin
      running_min <= min_next;
      beat_cnt    <= cnt_next;
      first       <= solution_stream.tlast;
      if (solution_stream.tlast) begin
        min_weight  <= min_next;
        frame_beats <= cnt_next;
      end
    end
  end

  // clear zeroes the base first, so a coincident acceptance lands on zero.
  always_comb begin
    sum_base   = clear ? '0 : total_sum;
    sum_ext    = {1'b0, sum_base} + (SUM_W+1)'(min_weight);
    sum_next   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    count_base = clear ? '0 : frame_count;
    count_next = (count_base == '1) ? count_base : count_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_sum   <= '0;
      frame_count <= '0;
    end else if (take) begin
      total_sum   <= sum_next;
      frame_count <= count_next;
    end else if (clear) begin
      total_sum   <= '0;
      frame_count <= '0;
    end
  end
endmodule

// File: tb/tb_min_weight_solution_sink.sv
// Scoreboard bench: stimulus queues hand-computed reports, a monitor checks them.
module tb_min_weight_solution_sink;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic mr1 = 1'b1;
  logic mr2 = 1'b1;

  logic [3:0]  mw1, mw2;
  logic [15:0] fb1, fb2;
  logic        mv1, mv2;
  logic [15:0] ts1;
  logic [3:0]  ts2;
  logic [15:0] fc1, fc2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int mw;
    int fb;
    int ts;
    int fc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  axi_stream_if #(.DATA_WIDTH(8)) s1 ();
  axi_stream_if #(.DATA_WIDTH(8)) s2 ();

  min_weight_solution_sink #(.DATA_WIDTH(8), .SUM_W(16), .BEATS_W(16)) dut (
    .clk(clk), .rst(rst), .solution_stream(s1), .clear(clear),
    .min_weight(mw1), .frame_beats(fb1), .min_valid(mv1), .min_ready(mr1),
    .total_sum(ts1), .frame_count(fc1)
  );

  min_weight_solution_sink #(.DATA_WIDTH(8), .SUM_W(4), .BEATS_W(16)) dut_sat (
    .clk(clk), .rst(rst), .solution_stream(s2), .clear(1'b0),
    .min_weight(mw2), .frame_beats(fb2), .min_valid(mv2), .min_ready(mr2),
    .total_sum(ts2), .frame_count(fc2)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic l);
    int n;
    logic rdy;
    n = 0;
    if (which == 0) begin s1.tvalid = 1'b1; s1.tdata = d; s1.tlast = l; end
    else            begin s2.tvalid = 1'b1; s2.tdata = d; s2.tlast = l; end
    forever begin
      @(negedge clk);
      rdy = (which == 0) ? s1.tready : s2.tready;
      if (rdy) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL send_timeout actual=no_tready required=tready");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (which == 0) s1.tvalid = 1'b0; else s2.tvalid = 1'b0;
  endtask

  task automatic expect_frame(input int mw, input int fb, input int ts, input int fc);
    exp_t e;
    e.mw = mw; e.fb = fb; e.ts = ts; e.fc = fc;
    q.push_back(e);
  endtask

  // Monitor: compare each accepted report, then the accumulators one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mv1 && mr1 && !rst) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_report actual=report required=none");
        end else begin
          e = q.pop_front();
          chk("min_weight", int'(mw1), e.mw);
          chk("frame_beats", int'(fb1), e.fb);
          @(negedge clk);
          chk("total_sum", int'(ts1), e.ts);
          chk("frame_count", int'(fc1), e.fc);
        end
      end
    end
  end

  initial begin
    s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0;
    s2.tvalid = 1'b0; s2.tdata = '0; s2.tlast = 1'b0;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tready", int'(s1.tready), 1);
    chk("reset_min_valid", int'(mv1), 0);
    chk("reset_min_weight", int'(mw1), 0);
    chk("reset_frame_beats", int'(fb1), 0);
    chk("reset_total_sum", int'(ts1), 0);
    chk("reset_frame_count", int'(fc1), 0);
    cyc(1);

    // Three-beat frame: weights 2,1,3.
    expect_frame(1, 3, 1, 1);
    send(0, 8'hC0, 1'b0);
    send(0, 8'h80, 1'b0);
    send(0, 8'hE0, 1'b1);
    @(negedge clk);
    chk("valid_after_tlast", int'(mv1), 1);
    @(negedge clk);
    chk("valid_one_cycle", int'(mv1), 0);
    cyc(2);

    // Single-beat frame.
    expect_frame(4, 1, 5, 2);
    send(0, 8'hF0, 1'b1);
    @(negedge clk);
    chk("single_valid", int'(mv1), 1);
    cyc(3);

    // Backpressure: junk on the stream must be ignored while held.
    mr1 = 1'b0;
    expect_frame(2, 2, 7, 3);
    send(0, 8'h03, 1'b0);
    send(0, 8'hE0, 1'b1);
    s1.tvalid = 1'b1; s1.tdata = 8'h00; s1.tlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_tready", int'(s1.tready), 0);
      chk("hold_valid", int'(mv1), 1);
      chk("hold_min_weight", int'(mw1), 2);
      chk("hold_frame_beats", int'(fb1), 2);
      chk("hold_total_sum", int'(ts1), 5);
    end
    cyc(1);
    s1.tvalid = 1'b0;
    mr1 = 1'b1;
    cyc(3);

    // Frame with a tvalid gap: weights 4,2.
    expect_frame(2, 2, 9, 4);
    send(0, 8'h0F, 1'b0);
    cyc(3);
    send(0, 8'h30, 1'b1);
    cyc(4);

    // Clear coincident with acceptance of min 3.
    mr1 = 1'b0;
    expect_frame(3, 1, 3, 1);
    send(0, 8'h07, 1'b1);
    clear = 1'b1;
    mr1 = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    cyc(3);

    // Clear alone.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    @(negedge clk);
    chk("clear_total_sum", int'(ts1), 0);
    chk("clear_frame_count", int'(fc1), 0);
    cyc(1);

    // All-zero beat drives the minimum to zero.
    expect_frame(0, 2, 0, 1);
    send(0, 8'hFF, 1'b0);
    send(0, 8'h00, 1'b1);
    cyc(3);

    // Reset mid-frame discards the partial frame.
    send(0, 8'hFF, 1'b0);
    send(0, 8'hFF, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_frame_count", int'(fc1), 0);
    chk("midrst_tready", int'(s1.tready), 1);
    cyc(1);
    expect_frame(1, 1, 1, 1);
    send(0, 8'h80, 1'b1);
    cyc(4);

    // Saturating accumulator on the 4-bit instance.
    send(1, 8'hFF, 1'b1);
    cyc(3);
    chk("sat_first_sum", int'(ts2), 8);
    chk("sat_first_min", int'(mw2), 8);
    send(1, 8'hFF, 1'b1);
    cyc(3);
    chk("sat_total_sum", int'(ts2), 15);
    chk("sat_frame_count", int'(fc2), 2);

    cyc(5);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
